// File: rtl/qracc_pkg.sv
// qracc_pkg: shared SRAM sequencer state encoding and default timing constants.
package qracc_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_PCH, S_WL, S_SA, S_WR, S_VPCH, S_VWL, S_VSA
  } sram_seq_state_t;
  localparam int DefPchCycles = 1;
  localparam int DefWlCycles = 1;
endpackage

// File: rtl/wl_decoder.sv
// wl_decoder: row address plus enable to one-hot wordline, all zero when the address is out of range.
module wl_decoder #(
  parameter int numRows = 128,
  parameter int AW = $clog2(numRows)
) (
  input  logic [AW-1:0]      addr_i,
  input  logic               en_i,
  output logic [numRows-1:0] wl_o
);
  // Shifting past the vector width yields zero, which covers rows >= numRows.
  assign wl_o = en_i ? {{(numRows-1){1'b0}}, 1'b1} << addr_i : '0;
endmodule

// File: rtl/sram_seq_ctrl.sv
// sram_seq_ctrl: sequences precharge/wordline/sense/write pins for one SRAM request at a time.
// Define SRAM_SEQ_WRITE_VERIFY_EN to add a read-back check after every write.
module sram_seq_ctrl import qracc_pkg::*; #(
  parameter int numRows = 128,
  parameter int numCols = 32,
  parameter int PchCycles = DefPchCycles,
  parameter int WlCycles = DefWlCycles
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       rq_wr_i,
  input  logic                       rq_valid_i,
  output logic                       rq_ready_o,
  input  logic [$clog2(numRows)-1:0] addr_i,
  input  logic [numCols-1:0]         wr_data_i,
  output logic                       rd_valid_o,
  output logic [numCols-1:0]         rd_data_o,
  output logic                       wr_err_o,
  output logic [numRows-1:0]         WL,
  output logic                       PCH,
  output logic                       WRITE,
  output logic [numCols-1:0]         WR_DATA,
  output logic [numCols-1:0]         CSEL,
  output logic                       SAEN,
  input  logic [numCols-1:0]         SA_OUT
);
  localparam int AW = $clog2(numRows);
  localparam int MaxCyc = PchCycles > WlCycles ? PchCycles : WlCycles;
  localparam int CW = $clog2(MaxCyc + 1);
  localparam logic [CW-1:0] PchLd = CW'(PchCycles - 1);
  localparam logic [CW-1:0] WlLd = CW'(WlCycles - 1);

  sram_seq_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic wr_q, ready_q, rd_valid_q, pch_q, write_q, saen_q;
  logic [AW-1:0] addr_q;
  logic [numCols-1:0] data_q, rd_data_q, wr_data_q, csel_q;
  logic [numRows-1:0] wl_q, wl_d;
  logic hs, done, wl_en_d, in_range;

  assign hs = rq_valid_i & rq_ready_o;
  assign done = cnt_q == '0;
  assign in_range = int'(addr_q) < numRows;
  assign wl_en_d = state_d inside {S_WL, S_SA, S_WR, S_VWL, S_VSA};

  always_comb begin
    state_d = state_q;
    cnt_d = done ? cnt_q : cnt_q - CW'(1);
    case (state_q)
      S_IDLE: if (hs) begin state_d = S_PCH; cnt_d = PchLd; end
      S_PCH:  if (done) begin state_d = wr_q ? S_WR : S_WL; cnt_d = WlLd; end
      S_WL:   if (done) state_d = S_SA;
      S_SA:   state_d = S_IDLE;
`ifdef SRAM_SEQ_WRITE_VERIFY_EN
      S_WR:   if (done) begin state_d = S_VPCH; cnt_d = PchLd; end
      S_VPCH: if (done) begin state_d = S_VWL; cnt_d = WlLd; end
      S_VWL:  if (done) state_d = S_VSA;
      S_VSA:  state_d = S_IDLE;
`else
      S_WR:   if (done) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  wl_decoder #(.numRows(numRows), .AW(AW)) u_wl_decoder (
    .addr_i(addr_q),
    .en_i  (wl_en_d),
    .wl_o  (wl_d)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      wr_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      ready_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q <= '0;
      pch_q <= 1'b0;
      write_q <= 1'b0;
      saen_q <= 1'b0;
      wl_q <= '0;
      wr_data_q <= '0;
      csel_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (hs) begin
        wr_q <= rq_wr_i;
        addr_q <= addr_i;
        data_q <= wr_data_i;
      end
      ready_q <= state_d == S_IDLE;
      rd_valid_q <= state_q == S_SA;
      if (state_q == S_SA) rd_data_q <= in_range ? SA_OUT : '0;
      pch_q <= state_d inside {S_PCH, S_VPCH};
      write_q <= state_d == S_WR;
      saen_q <= state_d inside {S_SA, S_VSA};
      wl_q <= wl_d;
      wr_data_q <= state_d == S_WR ? data_q : '0;
      csel_q <= state_d == S_WR ? '1 : '0;
    end
  end

`ifdef SRAM_SEQ_WRITE_VERIFY_EN
  logic wr_err_q;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) wr_err_q <= 1'b0;
    else wr_err_q <= state_q == S_VSA && SA_OUT != data_q;
  end
  assign wr_err_o = wr_err_q;
`else
  assign wr_err_o = 1'b0;
`endif

  assign rq_ready_o = ready_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_data_o = rd_data_q;
  assign WL = wl_q;
  assign PCH = pch_q;
  assign WRITE = write_q;
  assign WR_DATA = wr_data_q;
  assign CSEL = csel_q;
  assign SAEN = saen_q;
endmodule

// File: tb/tb_sram_seq_ctrl.sv
// tb_sram_seq_ctrl: directed checks of sram_seq_ctrl at default timing and at P=3/W=2 with 100 rows.
module tb_sram_seq_ctrl;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic v = 0, wr = 0, rdy, rv, err, pch, wre, saen;
  logic [6:0] addr = '0;
  logic [31:0] wd = '0, sa = '0, rd, wdo, csel;
  logic [127:0] wl;

  logic v2 = 0, wr2 = 0, rdy2, rv2, err2, pch2, wre2, saen2;
  logic [6:0] addr2 = '0;
  logic [31:0] wd2 = '0, sa2 = '0, rd2, wdo2, csel2;
  logic [99:0] wl2;

  int n_chk = 0, n_err = 0;

  sram_seq_ctrl dut (
    .clk(clk), .nrst(nrst), .rq_wr_i(wr), .rq_valid_i(v), .rq_ready_o(rdy),
    .addr_i(addr), .wr_data_i(wd), .rd_valid_o(rv), .rd_data_o(rd), .wr_err_o(err),
    .WL(wl), .PCH(pch), .WRITE(wre), .WR_DATA(wdo), .CSEL(csel), .SAEN(saen), .SA_OUT(sa)
  );

  sram_seq_ctrl #(.numRows(100), .numCols(32), .PchCycles(3), .WlCycles(2)) dut2 (
    .clk(clk), .nrst(nrst), .rq_wr_i(wr2), .rq_valid_i(v2), .rq_ready_o(rdy2),
    .addr_i(addr2), .wr_data_i(wd2), .rd_valid_o(rv2), .rd_data_o(rd2), .wr_err_o(err2),
    .WL(wl2), .PCH(pch2), .WRITE(wre2), .WR_DATA(wdo2), .CSEL(csel2), .SAEN(saen2), .SA_OUT(sa2)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3;
    chk("rst_ready", rdy, 0);
    chk("rst_wl", wl, 0);
    chk("rst_pch", pch, 0);
    chk("rst_rd_data", rd, 0);
    #9 nrst = 1'b1;
    step();
    chk("ready_after_rst", rdy, 1);
    chk("ready2_after_rst", rdy2, 1);

    // read row 5
    v = 1; wr = 0; addr = 7'd5; sa = 32'hA5A5_0F0F;
    step();
    v = 0; addr = 7'd66;
    chk("rd_c1_pch", pch, 1);
    chk("rd_c1_wl", wl, 0);
    chk("rd_c1_ready", rdy, 0);
    step();
    chk("rd_c2_pch", pch, 0);
    chk("rd_c2_wl", wl, 128'(1) << 5);
    chk("rd_c2_saen", saen, 0);
    step();
    chk("rd_c3_saen", saen, 1);
    chk("rd_c3_wl", wl, 128'(1) << 5);
    chk("rd_c3_rv", rv, 0);
    step();
    chk("rd_c4_rv", rv, 1);
    chk("rd_c4_data", rd, 32'hA5A5_0F0F);
    chk("rd_c4_ready", rdy, 1);
    chk("rd_c4_wl", wl, 0);
    sa = 32'h0;
    step();
    chk("rd_c5_rv", rv, 0);
    chk("rd_c5_hold", rd, 32'hA5A5_0F0F);

    // write row 127
    v = 1; wr = 1; addr = 7'd127; wd = 32'hDEAD_BEEF; sa = 32'hDEAD_BEEF;
    step();
    v = 0; wd = 32'h0;
    chk("wr_c1_pch", pch, 1);
    chk("wr_c1_write", wre, 0);
    step();
    chk("wr_c2_wl", wl, 128'(1) << 127);
    chk("wr_c2_write", wre, 1);
    chk("wr_c2_csel", csel, 32'hFFFF_FFFF);
    chk("wr_c2_data", wdo, 32'hDEAD_BEEF);
    chk("wr_c2_pch", pch, 0);
    step();
`ifdef SRAM_SEQ_WRITE_VERIFY_EN
    chk("wr_c3_vpch", pch, 1);
    chk("wr_c3_ready", rdy, 0);
    repeat (3) step();
`endif
    chk("wr_end_ready", rdy, 1);
    chk("wr_end_write", wre, 0);
    chk("wr_end_csel", csel, 0);
    chk("wr_end_data", wdo, 0);
    chk("wr_end_err", err, 0);
    chk("wr_end_rv", rv, 0);
    chk("wr_end_rd_hold", rd, 32'hA5A5_0F0F);
    wr = 0;

    // valid held high with changing address
    v = 1; addr = 7'd9; sa = 32'h0BAD_F00D;
    step();
    chk("b2b_c1_ready", rdy, 0);
    addr = 7'd20;
    step();
    chk("b2b_c2_wl", wl, 128'(1) << 9);
    addr = 7'd30;
    step();
    chk("b2b_c3_wl", wl, 128'(1) << 9);
    chk("b2b_c3_saen", saen, 1);
    step();
    chk("b2b_c4_rv", rv, 1);
    chk("b2b_c4_data", rd, 32'h0BAD_F00D);
    chk("b2b_c4_ready", rdy, 1);
    step();
    v = 0;
    chk("b2b2_c1_pch", pch, 1);
    chk("b2b2_c1_rv", rv, 0);
    step();
    chk("b2b2_c2_wl", wl, 128'(1) << 30);
    repeat (2) step();
    chk("b2b2_c4_rv", rv, 1);
    step();

    // async reset during WL
    v = 1; addr = 7'd3; sa = 32'h1234_5678;
    step();
    v = 0;
    step();
    chk("arst_pre_wl", wl, 128'(1) << 3);
    #2 nrst = 1'b0;
    #1;
    chk("arst_wl", wl, 0);
    chk("arst_ready", rdy, 0);
    chk("arst_rd_data", rd, 0);
    step();
    chk("arst_rv", rv, 0);
    chk("arst_saen", saen, 0);
    #3 nrst = 1'b1;
    step();
    chk("arst_ready_rel", rdy, 1);
    chk("arst_rv_rel", rv, 0);
    step();
    chk("arst_rv_rel2", rv, 0);

    // P=3 W=2, 100 rows
    v2 = 1; wr2 = 0; addr2 = 7'd2; sa2 = 32'h1234_5678;
    step();
    v2 = 0;
    chk("p3_c1_pch", pch2, 1);
    repeat (2) step();
    chk("p3_c3_pch", pch2, 1);
    chk("p3_c3_wl", wl2, 0);
    step();
    chk("p3_c4_pch", pch2, 0);
    chk("p3_c4_wl", wl2, 100'(1) << 2);
    step();
    chk("p3_c5_saen", saen2, 0);
    step();
    chk("p3_c6_saen", saen2, 1);
    chk("p3_c6_rv", rv2, 0);
    step();
    chk("p3_c7_rv", rv2, 1);
    chk("p3_c7_data", rd2, 32'h1234_5678);
    chk("p3_c7_ready", rdy2, 1);

    // out-of-range row on 100-row instance
    v2 = 1; addr2 = 7'd110; sa2 = 32'hFFFF_FFFF;
    step();
    v2 = 0;
    repeat (3) step();
    chk("oor_c4_wl", wl2, 0);
    step();
    chk("oor_c5_wl", wl2, 0);
    step();
    chk("oor_c6_saen", saen2, 1);
    step();
    chk("oor_c7_rv", rv2, 1);
    chk("oor_c7_data", rd2, 0);

`ifdef SRAM_SEQ_WRITE_VERIFY_EN
    v = 1; wr = 1; addr = 7'd10; wd = 32'h1; sa = 32'h0;
    step();
    v = 0;
    repeat (4) step();
    chk("vfy_bad_c5_err", err, 0);
    step();
    chk("vfy_bad_c6_err", err, 1);
    chk("vfy_bad_c6_ready", rdy, 1);
    chk("vfy_bad_c6_rv", rv, 0);
    chk("vfy_bad_c6_rd", rd, 0);
    step();
    chk("vfy_bad_c7_err", err, 0);
    v = 1; sa = 32'h1;
    step();
    v = 0;
    repeat (5) step();
    chk("vfy_ok_c6_err", err, 0);
    chk("vfy_ok_c6_ready", rdy, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/sram_seq_ctrl.md
# sram_seq_ctrl

Digital sequencer between the SRAM request handshake (`sram_itf` slave side) and the analog macro's SRAM control pins. Accepts one read or write request at a time, drives precharge, one-hot wordline, write enable, column select and sense-amp enable in a fixed cycle sequence, and returns sense-amp data with a valid pulse. Sits directly upstream of the analog column array and downstream of the QRAcc controller / weight loader.

## Interface
Parameters:
- `numRows`, 128, SRAM rows (wordlines)
- `numCols`, 32, SRAM columns (word width)
- `PchCycles`, 1, precharge duration in cycles (>=1)
- `WlCycles`, 1, wordline-active duration before sense/end of write (>=1)

Ports:
- `clk` in 1 — the single clock
- `nrst` in 1 — asynchronous, active-low reset
- `rq_wr_i` in 1 — 1 = write, 0 = read
- `rq_valid_i` in 1 — request valid
- `rq_ready_o` out 1 — request accepted on `rq_valid_i & rq_ready_o` at a rising edge
- `addr_i` in $clog2(numRows) — row address
- `wr_data_i` in numCols — write data
- `rd_valid_o` out 1 — one-cycle pulse; `rd_data_o` valid
- `rd_data_o` out numCols — read data, held until next read completes
- `wr_err_o` out 1 — write-verify mismatch pulse (see Configuration)
- `WL` out numRows — one-hot wordline
- `PCH` out 1 — bitline precharge
- `WRITE` out 1 — write driver enable
- `WR_DATA` out numCols — write driver data
- `CSEL` out numCols — column select
- `SAEN` out 1 — sense-amp enable
- `SA_OUT` in numCols — sense-amp outputs

## Operation
- States: IDLE, PCH, WL, SA, WR (plus VPCH, VWL, VSA when verify compiled in).
- IDLE: `rq_ready_o`=1, all analog outputs 0. On handshake latch `rq_wr_i`, `addr_i`, `wr_data_i`; later input changes are ignored.
- PCH: `PCH`=1 for PchCycles, then WL (read) or WR (write).
- WL (read): `WL[addr]`=1 for WlCycles, then SA.
- SA: `WL[addr]`=1, `SAEN`=1 for one cycle; `SA_OUT` registered into `rd_data_o` at exit edge, `rd_valid_o` pulses, next state IDLE.
- WR: `WL[addr]`=1, `WRITE`=1, `WR_DATA`=latched data, `CSEL`=all ones, for WlCycles; then IDLE.
- `CSEL`=0 and `WR_DATA`=0 outside WR.
- Single down-counter, width $clog2(max(PchCycles,WlCycles)+1), loaded on state entry.
- `rq_valid_i` while busy: ignored, ready low, no queueing.
- Address >= numRows (non-power-of-2 numRows): request accepted, `WL` stays 0; a read returns `rd_data_o`=0 with normal `rd_valid_o` timing.
- Async reset mid-operation: in-flight request dropped; no `rd_valid_o`/`wr_err_o`; `rd_data_o` cleared.

## Timing
- All outputs reset to 0 except `rq_ready_o`=1 once `nrst` deasserts (0 during reset). All outputs registered.
- Handshake edge = E0; cycle n = cycle after the nth edge after E0.
- Read: PCH cycles 1..P, WL P+1..P+W, SA P+W+1; `rd_valid_o` and `rq_ready_o` high in cycle P+W+2 (defaults: cycle 4). Back-to-back read accepted at that edge.
- Write: PCH 1..P, WR P+1..P+W; `rq_ready_o` high in cycle P+W+1 (defaults: cycle 3).
- `WL` never asserted in the same cycle as `PCH`.

## Configuration
- `SRAM_SEQ_WRITE_VERIFY_EN` defined: after WR, runs VPCH/VWL/VSA (same durations as read) on the same row; compares `SA_OUT` to latched data; `wr_err_o` pulses one cycle on mismatch alongside ready return in cycle 2P+2W+2; `rd_valid_o` not asserted and `rd_data_o` unchanged for verify reads.
- Undefined: no verify states; `wr_err_o` tied 0; write timing as above.

## Structure
- `qracc_pkg`: `sram_seq_state_t` enum; default `PchCycles`/`WlCycles` constants.
- One sub-module: `wl_decoder` (address + enable -> one-hot `WL`, zero when out of range).

## Test plan
- Reset, read row 5 with `SA_OUT`=32'hA5A5_0F0F -> PCH cycle 1, WL[5] cycle 2, SAEN cycle 3, `rd_valid_o` and `rd_data_o`=32'hA5A5_0F0F cycle 4.
- Write row 127 data 32'hDEAD_BEEF -> PCH cycle 1, WL[127]/WRITE/CSEL=all ones/WR_DATA=32'hDEAD_BEEF cycle 2, ready cycle 3.
- `rq_valid_i` held high during a read with changing `addr_i` -> second request accepted only at cycle-4 edge; first read's WL stays at original row.
- PchCycles=3, WlCycles=2 read -> SAEN cycle 6, `rd_valid_o` cycle 7.
- `nrst` asserted during WL -> all outputs 0 immediately, no `rd_valid_o` pulse, ready high after release.
- Verify build: write 32'h1 with `SA_OUT` forced 32'h0 -> `wr_err_o` pulse cycle 6; `SA_OUT`=32'h1 -> no pulse.
